ifu_ibuf: RTL

IFU_IBUF -- requirements
Module: ifu_ibuf

---
 rtl/ifu_ibuf.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ifu_ibuf.sv
// Instruction fetch buffer: issues word-aligned fetch requests under a credit
// limit, pairs in-order responses with their request address, and presents
// them to the pipe register through a DEPTH-entry FIFO. A flush redirects the
// PC, empties the buffer and drops every response still in flight.
// Optional feature: define IFU_IBUF_BYPASS_EN to forward a response straight
// to inst_* when the FIFO is empty (zero-cycle response latency).
module ifu_ibuf #(
    parameter int                          DEPTH           = 4,
    parameter int                          INST_ADDR_WIDTH = 32,
    parameter int                          INST_DATA_WIDTH = 32,
    parameter logic [INST_ADDR_WIDTH-1:0]  RESET_PC        = 32'h0000_0000,
    parameter logic [INST_DATA_WIDTH-1:0]  INST_NOP        = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       req_valid_o,
    output logic [INST_ADDR_WIDTH-1:0] req_addr_o,
    input  logic                       req_ready_i,
    input  logic                       rsp_valid_i,
    input  logic [INST_DATA_WIDTH-1:0] rsp_inst_i,
    input  logic                       flush_flag_i,
    input  logic [INST_ADDR_WIDTH-1:0] flush_addr_i,
    input  logic                       stall_i,
    output logic [INST_DATA_WIDTH-1:0] inst_o,
    output logic [INST_ADDR_WIDTH-1:0] inst_addr_o,
    output logic                       inst_valid_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    // Instruction FIFO and request-address tag queue (no reset needed on storage)
    logic [INST_DATA_WIDTH-1:0] fifo_data [DEPTH];
    logic [INST_ADDR_WIDTH-1:0] fifo_addr [DEPTH];
    logic [INST_ADDR_WIDTH-1:0] tag_mem   [DEPTH];

    logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]              tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CW-1:0]              count_q, count_d;
    logic [CW-1:0]              out_q, out_d;
    logic [CW-1:0]              drop_q, drop_d;

    logic                       hs;
    logic                       rsp_live;
    logic                       push_fifo;
    logic                       pop_fifo;
    logic [INST_ADDR_WIDTH-1:0] tag_head;
    logic [CW:0]                credit_used;

    // Stale responses (drop_q != 0) never touch the tag queue or the FIFO.
    assign rsp_live    = rsp_valid_i && (drop_q == '0);
    assign tag_head    = tag_mem[tag_rd_q];
    assign credit_used = {1'b0, count_q} + {1'b0, out_q};
    assign req_valid_o = rst_n && !flush_flag_i && (credit_used < DEPTH_C);
    assign req_addr_o  = pc_q;
    assign hs          = req_valid_o && req_ready_i;
    assign pop_fifo    = (count_q != '0) && !stall_i && !flush_flag_i;

`ifdef IFU_IBUF_BYPASS_EN
    logic byp;
    assign byp       = rst_n && rsp_live && (count_q == '0) && !flush_flag_i;
    // A forwarded response that the pipe takes this cycle is not buffered.
    assign push_fifo = rsp_live && !flush_flag_i && !(byp && !stall_i);
`else
    assign push_fifo = rsp_live && !flush_flag_i;
`endif

    // Present FIFO head (or forwarded response); NOP/zero when nothing is valid
    always_comb begin
        inst_valid_o = 1'b0;
        inst_o       = INST_NOP;
        inst_addr_o  = '0;
        if (count_q != '0) begin
            inst_valid_o = 1'b1;
            inst_o       = fifo_data[rd_ptr_q];
            inst_addr_o  = fifo_addr[rd_ptr_q];
        end
`ifdef IFU_IBUF_BYPASS_EN
        else if (byp) begin
            inst_valid_o = 1'b1;
            inst_o       = rsp_inst_i;
            inst_addr_o  = tag_head;
        end
`endif
    end

    // Next-state: flush wins over request, response write, pop and stall
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        tag_wr_d = tag_wr_q;
        tag_rd_d = tag_rd_q;
        count_d  = count_q;
        out_d    = out_q + CW'(hs) - CW'(rsp_valid_i);
        drop_d   = drop_q;
        if (flush_flag_i) begin
            pc_d     = flush_addr_i;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            tag_wr_d = '0;
            tag_rd_d = '0;
            count_d  = '0;
            // Everything still outstanding after this cycle's response is stale.
            drop_d   = out_q - CW'(rsp_valid_i);
        end else begin
            if (hs) begin
                pc_d     = pc_q + INST_ADDR_WIDTH'(4);
                tag_wr_d = tag_wr_q + PW'(1);
            end
            if (rsp_live)
                tag_rd_d = tag_rd_q + PW'(1);
            if (rsp_valid_i && (drop_q != '0))
                drop_d = drop_q - CW'(1);
            if (push_fifo)
                wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_fifo)
                rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_fifo) - CW'(pop_fifo);
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            drop_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
            count_q  <= count_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
        end
    end

    // Storage writes: tag on request handshake, instruction+address on response
    always_ff @(posedge clk) begin
        if (hs)
            tag_mem[tag_wr_q] <= pc_q;
        if (push_fifo) begin
            fifo_data[wr_ptr_q] <= rsp_inst_i;
            fifo_addr[wr_ptr_q] <= tag_head;
        end
    end

endmodule
